data_assembler: RTL

Packs a stream of narrow words (default 32-bit) into wide words (default 256-bit). It is the collecting end of the wide-to-narrow serialization path: it gathers per-element results from the multiplier datapath into full-width words for write-back. The input side uses a valid/ready handshake with backpressure. The output is a registered valid/ready slot, so sustained throughput is one input beat per cycle.

---
 rtl/data_assembler.sv | 98 +++++++++
 1 files changed

// File: rtl/data_assembler.sv
// Packs a stream of IW-bit beats, LSB lane first, into OW-bit words behind a registered valid/ready output slot.
// Optional feature: define DATA_ASSEMBLER_LAST_EN to add last_i, which closes a word early.
module data_assembler #(
    parameter int DATA_INPUT_WIDTH  = 32,
    parameter int DATA_OUTPUT_WIDTH = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_i,
    input  logic [DATA_INPUT_WIDTH-1:0]  data_i,
    output logic                         ready_o,
`ifdef DATA_ASSEMBLER_LAST_EN
    input  logic                         last_i,
`endif
    output logic [DATA_OUTPUT_WIDTH-1:0] data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         busy_o
);

    localparam int IW = DATA_INPUT_WIDTH;
    localparam int OW = DATA_OUTPUT_WIDTH;
    localparam int N  = OW / IW;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] TOP_LANE = CW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    logic          last_in;
    logic          slot_free;
    logic          at_top;
    logic          accept;
    logic          close;
    logic [OW-1:0] merged;

`ifdef DATA_ASSEMBLER_LAST_EN
    assign last_in = last_i;
`else
    assign last_in = 1'b0;
`endif

    assign slot_free = ~valid_q | ready_i;
    assign at_top    = (cnt_q == TOP_LANE);
    // Only a closing beat needs the output slot; beats into lower lanes never stall.
    assign ready_o   = (~at_top & ~last_in) | slot_free;
    assign accept    = valid_i & ready_o;
    assign close     = accept & (at_top | last_in);

    // Accumulator with the current beat dropped into lane cnt_q.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign merged[gi*IW +: IW] = (cnt_q == CW'(gi)) ? data_i : acc_q[gi*IW +: IW];
        end
    endgenerate

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (close) begin
            // Clearing acc here is what keeps lanes above an early close at zero.
            cnt_d   = '0;
            acc_d   = '0;
            data_d  = merged;
            valid_d = 1'b1;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = (cnt_q != '0);

endmodule
